// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_PORTS AXI4-Stream masters share one sink through a
// registered output slice. A grant lasts from a packet's first beat to its TLAST beat.
module axis_rr_arbiter #(
  parameter int NUM_PORTS          = 4,
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH        = 1
) (
  input  logic                                            axis_aclk,
  input  logic                                            axis_areset,
  input  logic [NUM_PORTS*C_AXIS_TDATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [NUM_PORTS*(C_AXIS_TDATA_WIDTH/8)-1:0]     s_axis_tstrb,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0]                s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                            s_axis_tlast,
  input  logic [NUM_PORTS-1:0]                            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                            s_axis_tready,
  input  logic [NUM_PORTS-1:0]                            port_enable,
  output logic [C_AXIS_TDATA_WIDTH-1:0]                   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]                 m00_axis_tstrb,
  output logic [TUSER_WIDTH-1:0]                          m00_axis_tuser,
  output logic                                            m00_axis_tlast,
  output logic                                            m00_axis_tvalid,
  input  logic                                            m00_axis_tready,
  output logic                                            grant_active,
  output logic [$clog2(NUM_PORTS)-1:0]                    grant_index
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int DW = C_AXIS_TDATA_WIDTH;
  localparam int SW = C_AXIS_TDATA_WIDTH / 8;
  localparam int UW = TUSER_WIDTH;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  state_e        state_q, state_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [GW-1:0] grant_index_q, grant_index_d;
  beat_t         out_q, out_d;
  logic          out_valid_q, out_valid_d;

  logic                 out_ready;
  logic                 beat_xfer;
  logic [NUM_PORTS-1:0] req;
  logic [GW-1:0]        winner;
  logic                 winner_found;
  beat_t                sel_beat;
  logic                 sel_valid;
  logic [NUM_PORTS-1:0] grant_onehot;

  assign out_ready = m00_axis_tready | ~out_valid_q;
  assign req       = s_axis_tvalid & port_enable;

  // Rotating priority: the port just after the last packet's owner is searched first.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!winner_found && req[GW'((int'(last_grant_q) + k) % NUM_PORTS)]) begin
        winner       = GW'((int'(last_grant_q) + k) % NUM_PORTS);
        winner_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_beat     = '0;
    sel_valid    = 1'b0;
    grant_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_index_q == GW'(i)) begin
        sel_beat.data   = s_axis_tdata[i*DW +: DW];
        sel_beat.strb   = s_axis_tstrb[i*SW +: SW];
        sel_beat.user   = s_axis_tuser[i*UW +: UW];
        sel_beat.last   = s_axis_tlast[i];
        sel_valid       = s_axis_tvalid[i];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  assign s_axis_tready = (state_q == BUSY && out_ready) ? grant_onehot : '0;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_index_d = grant_index_q;
    out_d         = out_q;
    out_valid_d   = out_valid_q;
    beat_xfer     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (winner_found) begin
          grant_index_d = winner;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        // port_enable is deliberately not consulted here: an accepted packet always completes.
        beat_xfer = sel_valid & out_ready;
        if (beat_xfer && sel_beat.last) begin
          last_grant_d = grant_index_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (beat_xfer) begin
      out_d       = sel_beat;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q       <= IDLE;
      last_grant_q  <= GW'(NUM_PORTS - 1);
      grant_index_q <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_index_q <= grant_index_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign m00_axis_tdata  = out_q.data;
  assign m00_axis_tstrb  = out_q.strb;
  assign m00_axis_tuser  = out_q.user;
  assign m00_axis_tlast  = out_q.last;
  assign m00_axis_tvalid = out_valid_q;
  assign grant_active    = (state_q == BUSY);
  assign grant_index     = grant_index_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: directed scenarios plus randomized rounds scored against
// a packet-level round-robin model.
module tb_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int UW = 1;
  localparam int GW = $clog2(N);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            axis_areset;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*SW-1:0] s_axis_tstrb;
  logic [N*UW-1:0] s_axis_tuser;
  logic [N-1:0]    s_axis_tlast;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [N-1:0]    port_enable;
  logic [DW-1:0]   m00_axis_tdata;
  logic [SW-1:0]   m00_axis_tstrb;
  logic [UW-1:0]   m00_axis_tuser;
  logic            m00_axis_tlast;
  logic            m00_axis_tvalid;
  logic            m00_axis_tready;
  logic            grant_active;
  logic [GW-1:0]   grant_index;

  always #5 clk = ~clk;

  axis_rr_arbiter #(
    .NUM_PORTS(N), .C_AXIS_TDATA_WIDTH(DW), .TUSER_WIDTH(UW)
  ) dut (
    .axis_aclk      (clk),
    .axis_areset    (axis_areset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tstrb   (s_axis_tstrb),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .port_enable    (port_enable),
    .m00_axis_tdata (m00_axis_tdata),
    .m00_axis_tstrb (m00_axis_tstrb),
    .m00_axis_tuser (m00_axis_tuser),
    .m00_axis_tlast (m00_axis_tlast),
    .m00_axis_tvalid(m00_axis_tvalid),
    .m00_axis_tready(m00_axis_tready),
    .grant_active   (grant_active),
    .grant_index    (grant_index)
  );

  beat_t       src_q [N][$];
  beat_t       exp_q [$];
  int          plen  [N][$];
  logic [31:0] pbase [N][$];
  logic [N-1:0] mid_pkt;
  logic [N-1:0] bubble;
  logic         rand_mode;
  logic         cleared;
  int           compared   = 0;
  int           mismatched = 0;
  int           t2_v [10]  = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
  int           t3_m [8]   = '{0, 1, 0, 1, 0, 1, 0, 1};
  int           t3_r [8]   = '{1, 1, 0, 1, 0, 1, 0, 0};
  int           t3_d [8]   = '{0, 32'h3300, 32'h3301, 32'h3301, 32'h3302, 32'h3302, 32'h3303, 32'h3303};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.strb = d[SW-1:0] ^ d[7:4];
    b.user = d[4];
    b.last = l;
    return b;
  endfunction

  task automatic src_pkt(input int port, input int len, input logic [31:0] base);
    for (int j = 0; j < len; j++) src_q[port].push_back(mk_beat(base + 32'(j), j == len - 1));
  endtask

  task automatic exp_pkt(input int len, input logic [31:0] base);
    for (int j = 0; j < len; j++) exp_q.push_back(mk_beat(base + 32'(j), j == len - 1));
  endtask

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0 && !(bubble[i] && mid_pkt[i])) begin
        s_axis_tvalid[i]         = 1'b1;
        s_axis_tdata[i*DW +: DW] = src_q[i][0].data;
        s_axis_tstrb[i*SW +: SW] = src_q[i][0].strb;
        s_axis_tuser[i*UW +: UW] = src_q[i][0].user;
        s_axis_tlast[i]          = src_q[i][0].last;
      end else begin
        s_axis_tvalid[i]         = 1'b0;
        s_axis_tdata[i*DW +: DW] = '0;
        s_axis_tstrb[i*SW +: SW] = '0;
        s_axis_tuser[i*UW +: UW] = '0;
        s_axis_tlast[i]          = 1'b0;
      end
    end
  endtask

  // Entered and left at the falling edge; handshakes are sampled just after it, inputs change 1 after the rising edge.
  task automatic cycle();
    logic [N-1:0] hs;
    beat_t        got;
    #1;
    hs = s_axis_tvalid & s_axis_tready;
    if (m00_axis_tvalid && m00_axis_tready) begin
      got = {m00_axis_tdata, m00_axis_tstrb, m00_axis_tuser, m00_axis_tlast};
      check("out_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        check("out_beat", 64'(got), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && src_q[i].size() != 0) begin
        mid_pkt[i] = !src_q[i][0].last;
        void'(src_q[i].pop_front());
      end
    end
    if (rand_mode) begin
      bubble          = N'($urandom);
      m00_axis_tready = ($urandom_range(0, 9) < 7);
    end
    drive_sources();
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    axis_areset = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    mid_pkt = '0;
    bubble  = '0;
    drive_sources();
    repeat (2) @(posedge clk);
    @(negedge clk);
    axis_areset = 1'b0;
  endtask

  initial begin
    int last_p;
    int n_pkt;
    int len;
    logic [31:0] base;
    logic found;

    axis_areset     = 1'b0;
    rand_mode       = 1'b0;
    cleared         = 1'b0;
    mid_pkt         = '0;
    bubble          = '0;
    port_enable     = '1;
    m00_axis_tready = 1'b1;
    s_axis_tdata    = '1;
    s_axis_tstrb    = '1;
    s_axis_tuser    = '1;
    s_axis_tlast    = '1;
    s_axis_tvalid   = '1;

    // Reset state, with every source requesting.
    #2 axis_areset = 1'b1;
    #1;
    check("rst_tvalid", 64'(m00_axis_tvalid), 64'(0));
    check("rst_tdata", 64'(m00_axis_tdata), 64'(0));
    check("rst_tlast", 64'(m00_axis_tlast), 64'(0));
    check("rst_gactive", 64'(grant_active), 64'(0));
    check("rst_gindex", 64'(grant_index), 64'(0));
    check("rst_tready", 64'(s_axis_tready), 64'(0));
    do_reset();

    // 1: single 3-beat packet on port 0.
    src_pkt(0, 3, 32'h1);
    exp_pkt(3, 32'h1);
    drive_sources();
    check("t1_idle_tready", 64'(s_axis_tready), 64'(0));
    cycle();
    check("t1_gactive", 64'(grant_active), 64'(1));
    check("t1_gindex", 64'(grant_index), 64'(0));
    check("t1_novalid", 64'(m00_axis_tvalid), 64'(0));
    check("t1_tready", 64'(s_axis_tready), 64'(1));
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check("t1_valid", 64'(m00_axis_tvalid), 64'(1));
      check("t1_data", 64'(m00_axis_tdata), 64'(i));
      check("t1_last", 64'(m00_axis_tlast), 64'(i == 3));
    end
    check("t1_back_idle", 64'(grant_active), 64'(0));
    cycle();
    check("t1_valid_drop", 64'(m00_axis_tvalid), 64'(0));
    check("t1_gindex_hold", 64'(grant_index), 64'(0));
    check("t1_drained", 64'(exp_q.size()), 64'(0));

    // 2: ports 0,1,2 request together; order 0,1,2 with one gap cycle between packets.
    do_reset();
    src_pkt(0, 2, 32'h0200);
    src_pkt(1, 2, 32'h1200);
    src_pkt(2, 2, 32'h2200);
    exp_pkt(2, 32'h0200);
    exp_pkt(2, 32'h1200);
    exp_pkt(2, 32'h2200);
    drive_sources();
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("t2_valid_pattern", 64'(m00_axis_tvalid), 64'(t2_v[k]));
    end
    check("t2_drained", 64'(exp_q.size()), 64'(0));

    // 3: output backpressure toggling during a 4-beat packet.
    do_reset();
    src_pkt(0, 4, 32'h3300);
    exp_pkt(4, 32'h3300);
    drive_sources();
    cycle();
    for (int k = 0; k < 8; k++) begin
      m00_axis_tready = t3_m[k][0];
      #1;
      check("t3_tready", 64'(s_axis_tready), 64'(t3_r[k]));
      check("t3_valid", 64'(m00_axis_tvalid), 64'(k != 0));
      if (k != 0) check("t3_data", 64'(m00_axis_tdata), 64'(t3_d[k]));
      cycle();
    end
    check("t3_drained", 64'(exp_q.size()), 64'(0));
    check("t3_valid_end", 64'(m00_axis_tvalid), 64'(0));
    m00_axis_tready = 1'b1;

    // 4: enable mask 1010, bit 1 cleared in the middle of a port-1 packet.
    do_reset();
    port_enable = 4'b1010;
    src_pkt(0, 2, 32'h4000);
    src_pkt(2, 2, 32'h4200);
    src_pkt(1, 2, 32'h4100);
    src_pkt(1, 3, 32'h4110);
    src_pkt(3, 2, 32'h4300);
    src_pkt(3, 2, 32'h4310);
    exp_pkt(2, 32'h4100);
    exp_pkt(2, 32'h4300);
    exp_pkt(3, 32'h4110);
    exp_pkt(2, 32'h4310);
    drive_sources();
    cleared = 1'b0;
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
      cycle();
      if (!cleared && grant_active && grant_index == 2'd1 && src_q[1].size() == 2) begin
        port_enable = 4'b1000;
        cleared     = 1'b1;
      end
    end
    check("t4_drained", 64'(exp_q.size()), 64'(0));
    check("t4_midclear", 64'(cleared), 64'(1));
    repeat (3) cycle();
    check("t4_no_grant", 64'(grant_active), 64'(0));
    check("t4_port0_left", 64'(src_q[0].size()), 64'(2));
    check("t4_port2_left", 64'(src_q[2].size()), 64'(2));
    port_enable = '1;

    // 5: back-to-back single-beat packets on port 2, then port 3 joins.
    do_reset();
    for (int j = 0; j < 4; j++) src_pkt(2, 1, 32'h5200 + 32'(j));
    for (int j = 0; j < 3; j++) exp_pkt(1, 32'h5200 + 32'(j));
    drive_sources();
    for (int k = 1; k <= 6; k++) begin
      cycle();
      check("t5_valid", 64'(m00_axis_tvalid), 64'(k % 2 == 0));
      check("t5_gactive", 64'(grant_active), 64'(k % 2 == 1));
    end
    src_pkt(3, 1, 32'h5300);
    exp_pkt(1, 32'h5300);
    exp_pkt(1, 32'h5203);
    drive_sources();
    cycle();
    check("t5_port3_next", 64'(grant_index), 64'(3));
    drain("t5_drained", 20);

    // 6: reset asserted while beat 2 of 4 is offered.
    src_pkt(0, 4, 32'h6000);
    exp_pkt(4, 32'h6000);
    drive_sources();
    repeat (2) cycle();
    axis_areset = 1'b1;
    #1;
    check("t6_valid_clr", 64'(m00_axis_tvalid), 64'(0));
    check("t6_data_clr", 64'(m00_axis_tdata), 64'(0));
    check("t6_tready_clr", 64'(s_axis_tready), 64'(0));
    check("t6_gactive_clr", 64'(grant_active), 64'(0));
    do_reset();
    src_pkt(0, 2, 32'h6100);
    src_pkt(3, 2, 32'h6300);
    exp_pkt(2, 32'h6100);
    exp_pkt(2, 32'h6300);
    drive_sources();
    cycle();
    check("t6_first_port0", 64'(grant_index), 64'(0));
    check("t6_first_active", 64'(grant_active), 64'(1));
    drain("t6_drained", 20);

    // Randomized rounds: preloaded packets, random enables, bubbles and stalls.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      port_enable = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        plen[i].delete();
        pbase[i].delete();
        n_pkt = $urandom_range(0, 4);
        for (int p = 0; p < n_pkt; p++) begin
          len  = $urandom_range(1, 4);
          base = ($urandom & 32'h00FF_FFF0) | (32'(r) << 28) | (32'(i) << 24);
          src_pkt(i, len, base);
          plen[i].push_back(len);
          pbase[i].push_back(base);
        end
      end
      last_p = N - 1;
      found  = 1'b1;
      while (found) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!found && port_enable[(last_p + k) % N] && plen[(last_p + k) % N].size() != 0) begin
            found  = 1'b1;
            last_p = (last_p + k) % N;
            exp_pkt(plen[last_p].pop_front(), pbase[last_p].pop_front());
          end
        end
      end
      rand_mode = 1'b1;
      drive_sources();
      drain("rand_drained", 2000);
      rand_mode       = 1'b0;
      bubble          = '0;
      m00_axis_tready = 1'b1;
      repeat (3) cycle();
      check("rand_idle_end", 64'(grant_active), 64'(0));
    end
    port_enable = '1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
